// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_M0,
    ARB_M1
  } arb_state_e;

  typedef logic arb_idx_t;

  // m0 wins the first tie after reset.
  localparam arb_idx_t ARB_RESET_LAST = 1'b1;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bundle; master drives the request, slave drives stall/ack/err/data_s.
interface wishbone_if;
  import wb_arb_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [WB_AW-1:0]  addr;
  logic [WB_DW-1:0]  data_m;
  logic [WB_DW/8-1:0] sel;
  logic [WB_DW-1:0]  data_s;
  logic              stall;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, addr, data_m, sel,
    input  data_s, stall, ack, err
  );

  modport slave (
    input  cyc, stb, we, addr, data_m, sel,
    output data_s, stall, ack, err
  );

endinterface

// File: rtl/wb_arb_pick.sv
// Next-grant selector for the idle state. WB_ARB_FIXED_PRIO_EN: m0 always wins a tie;
// otherwise the master that was not granted last wins.
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_idx_t   last,
  output logic       grant_vld,
  output arb_idx_t   grant
);

`ifdef WB_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    grant_vld = |req;
    grant     = 1'b0;
    case (req)
      2'b01: grant = 1'b0;
      2'b10: grant = 1'b1;
      2'b11: begin
`ifdef WB_ARB_FIXED_PRIO_EN
        grant = 1'b0;
`else
        grant = ~last;
`endif
      end
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave pipelined Wishbone arbiter with outstanding-request tracking.
// Tie-break policy selected by WB_ARB_FIXED_PRIO_EN (see wb_arb_pick).
//
// state    | meaning
// ARB_IDLE | no owner; pick a requester, grant takes effect next cycle
// ARB_M0   | m0 owns the slave until m0.cyc falls
// ARB_M1   | m1 owns the slave until m1.cyc falls
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  wishbone_if.slave  m0,
  wishbone_if.slave  m1,
  wishbone_if.master s
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  arb_state_e       state_q, state_d;
  arb_idx_t         last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] req;
  logic       pick_vld;
  arb_idx_t   pick_idx;
  logic       cnt_full;
  logic       cnt_nz;
  logic       inc;
  logic       dec;

  assign req      = {m1.cyc, m0.cyc};
  assign cnt_full = (cnt_q == CNT_MAX);
  assign cnt_nz   = (cnt_q != '0);

  wb_arb_pick u_pick (
    .req       (req),
    .last      (last_q),
    .grant_vld (pick_vld),
    .grant     (pick_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_RESET_LAST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus muxing: only the owner is forwarded; everyone else sees stall and no responses.
  always_comb begin
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.addr    = '0;
    s.data_m  = '0;
    s.sel     = '0;
    m0.stall  = 1'b1;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.data_s = '0;
    m1.stall  = 1'b1;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.data_s = '0;
    case (state_q)
      ARB_M0: begin
        s.cyc     = m0.cyc;
        s.stb     = m0.stb & ~cnt_full;
        s.we      = m0.we;
        s.addr    = m0.addr;
        s.data_m  = m0.data_m;
        s.sel     = m0.sel;
        m0.stall  = s.stall | cnt_full;
        m0.data_s = s.data_s;
        m0.ack    = s.ack & cnt_nz;
        m0.err    = s.err & cnt_nz;
      end
      ARB_M1: begin
        s.cyc     = m1.cyc;
        s.stb     = m1.stb & ~cnt_full;
        s.we      = m1.we;
        s.addr    = m1.addr;
        s.data_m  = m1.data_m;
        s.sel     = m1.sel;
        m1.stall  = s.stall | cnt_full;
        m1.data_s = s.data_s;
        m1.ack    = s.ack & cnt_nz;
        m1.err    = s.err & cnt_nz;
      end
      default: ;
    endcase
  end

  assign inc = s.stb & ~s.stall & s.cyc;
  assign dec = (s.ack | s.err) & cnt_nz;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = pick_idx ? ARB_M1 : ARB_M0;
        end
      end
      ARB_M0: begin
        // Dropping cyc aborts the cycle; anything still outstanding is forgotten.
        if (!m0.cyc) begin
          state_d = ARB_IDLE;
          last_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ARB_M1: begin
        if (!m1.cyc) begin
          state_d = ARB_IDLE;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with a latency-programmable RAM slave model.
module tb_wb_arbiter_2m;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  wishbone_if m0_if ();
  wishbone_if m1_if ();
  wishbone_if s_if ();

  wb_arbiter_2m #(.MAX_OUTSTANDING(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM slave model: ack (or err) ack_lat cycles after acceptance, in order.
  typedef struct {
    int          due;
    logic        we;
    logic [31:0] addr;
    logic        err;
  } req_t;

  req_t        pq[$];
  logic [31:0] mem[64];
  int          edge_n = 0;
  int          acc_n  = 0;
  int          ack_lat = 1;
  int          err_at  = -1;

  function automatic req_t mk_req(int due, logic we, logic [31:0] a, logic err);
    req_t r;
    r.due  = due;
    r.we   = we;
    r.addr = a;
    r.err  = err;
    return r;
  endfunction

  assign s_if.stall = 1'b0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (s_if.cyc && s_if.stb && !s_if.stall) begin
      pq.push_back(mk_req(edge_n + ack_lat - 1, s_if.we, s_if.addr, (acc_n + 1 == err_at)));
      acc_n <= acc_n + 1;
      if (s_if.we) mem[s_if.addr[7:2]] <= s_if.data_m;
    end
    if (pq.size() != 0 && pq[0].due <= edge_n) begin
      s_if.ack    <= !pq[0].err;
      s_if.err    <= pq[0].err;
      s_if.data_s <= pq[0].we ? 32'h0 : mem[pq[0].addr[7:2]];
      void'(pq.pop_front());
    end else begin
      s_if.ack    <= 1'b0;
      s_if.err    <= 1'b0;
      s_if.data_s <= 32'h0;
    end
  end

  // Response monitor, sampled mid-cycle.
  int          m0_ack_n = 0, m1_ack_n = 0, m0_err_n = 0, m1_err_n = 0, s_resp_n = 0;
  int          max_cnt = 0;
  logic        cap_rd = 1'b0;
  logic [31:0] rd_q[$];

  always @(negedge clk) begin
    if (m0_if.ack) m0_ack_n <= m0_ack_n + 1;
    if (m1_if.ack) m1_ack_n <= m1_ack_n + 1;
    if (m0_if.err) m0_err_n <= m0_err_n + 1;
    if (m1_if.err) m1_err_n <= m1_err_n + 1;
    if (s_if.ack || s_if.err) s_resp_n <= s_resp_n + 1;
    if (cap_rd && m0_if.ack) rd_q.push_back(m0_if.data_s);
    if (int'(dut.cnt_q) > max_cnt) max_cnt <= int'(dut.cnt_q);
  end

  function automatic logic [31:0] st();
    return 32'(dut.state_q);
  endfunction

  int a0, a1, e0, e1, sr;
  bit got_ack;

  initial begin
    rst_n = 1'b0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h0;
    m0_if.data_m = 32'h0; m0_if.sel = 4'hF;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.addr = 32'h0;
    m1_if.data_m = 32'h0; m1_if.sel = 4'hF;

    // Reset holds everything idle even with m0 requesting.
    repeat (2) tick();
    chk("rst_s_cyc", s_if.cyc, 0);
    chk("rst_s_stb", s_if.stb, 0);
    chk("rst_m0_stall", m0_if.stall, 1);
    chk("rst_m1_stall", m1_if.stall, 1);
    chk("rst_m0_ack", m0_if.ack, 0);
    chk("rst_m0_err", m0_if.err, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_state", st(), 32'(ARB_IDLE));
    chk("post_rst_stall", m0_if.stall, 1);
    chk("post_rst_s_stb", s_if.stb, 0);
    tick();
    chk("grant_state", st(), 32'(ARB_M0));
    chk("first_s_stb", s_if.stb, 1);
    chk("grant_m0_stall", m0_if.stall, 0);
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    #1;
    chk("drop_s_cyc", s_if.cyc, 0);
    tick();
    chk("drop_idle", st(), 32'(ARB_IDLE));

    // Tie-break and alternation from a fresh reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
    chk("tie1_m0", st(), 32'(ARB_M0));
    chk("tie1_m1_stall", m1_if.stall, 1);
    m0_if.cyc = 1'b0;
    tick();
    chk("gap_idle", st(), 32'(ARB_IDLE));
    chk("gap_m1_stall", m1_if.stall, 1);
    tick();
    chk("then_m1", st(), 32'(ARB_M1));
    chk("then_m1_stall", m1_if.stall, 0);
    m1_if.cyc = 1'b0;
    tick();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
    chk("tie2_m0", st(), 32'(ARB_M0));
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    tick();
    m0_if.cyc = 1'b1; m1_if.cyc = 1'b1;
    tick();
`ifdef WB_ARB_FIXED_PRIO_EN
    chk("tie3_fixed", st(), 32'(ARB_M0));
`else
    chk("tie3_rr", st(), 32'(ARB_M1));
`endif
    m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    tick();

    // Six-write burst with 1-cycle RAM ack, then readback.
    ack_lat = 1;
    a0 = m0_ack_n; a1 = m1_ack_n;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
    m0_if.addr = 32'h0; m0_if.data_m = 32'hA0;
    tick();
    for (int i = 0; i < 6; i++) begin
      m0_if.addr = 32'(i * 4);
      m0_if.data_m = 32'(32'hA0 + i);
      tick();
    end
    m0_if.stb = 1'b0; m0_if.we = 1'b0;
    repeat (2) tick();
    chk("burst_m0_acks", 32'(m0_ack_n - a0), 6);
    chk("burst_m1_acks", 32'(m1_ack_n - a1), 0);
    chk("burst_max_cnt", 32'(max_cnt), 1);
    m0_if.cyc = 1'b0;
    tick();
    cap_rd = 1'b1;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.addr = 32'h0;
    tick();
    for (int i = 0; i < 6; i++) begin
      m0_if.addr = 32'(i * 4);
      tick();
    end
    m0_if.stb = 1'b0;
    repeat (2) tick();
    cap_rd = 1'b0;
    chk("rd_count", 32'(rd_q.size()), 6);
    for (int i = 0; i < 6 && i < rd_q.size(); i++)
      chk($sformatf("rd_data%0d", i), rd_q[i], 32'(32'hA0 + i));
    m0_if.cyc = 1'b0;
    tick();

    // Slow slave: counter fills to 4, stalls, then drains.
    ack_lat = 8;
    a0 = m0_ack_n;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.addr = 32'h0;
    tick();
    repeat (3) tick();
    chk("fill_cnt3", 32'(dut.cnt_q), 3);
    chk("fill_stall3", m0_if.stall, 0);
    tick();
    chk("full_cnt", 32'(dut.cnt_q), 4);
    chk("full_stall", m0_if.stall, 1);
    chk("full_s_stb", s_if.stb, 0);
    tick();
    chk("full_hold_cnt", 32'(dut.cnt_q), 4);
    chk("full_hold_s_stb", s_if.stb, 0);
    m0_if.stb = 1'b0;
    got_ack = 1'b0;
    for (int k = 0; k < 16 && !got_ack; k++) begin
      if (m0_if.ack) got_ack = 1'b1;
      else tick();
    end
    chk("drain_ack_seen", 32'(got_ack), 1);
    chk("drain_cnt4", 32'(dut.cnt_q), 4);
    for (int j = 3; j >= 0; j--) begin
      tick();
      chk($sformatf("drain_cnt%0d", j), 32'(dut.cnt_q), 32'(j));
    end
    tick();
    chk("drain_acks", 32'(m0_ack_n - a0), 4);
    m0_if.cyc = 1'b0;
    tick();

    // Abort with two outstanding; late acks must be swallowed.
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    tick();
    repeat (2) tick();
    m0_if.stb = 1'b0;
    chk("abort_cnt2", 32'(dut.cnt_q), 2);
    a0 = m0_ack_n; a1 = m1_ack_n; sr = s_resp_n;
    m0_if.cyc = 1'b0;
    #1;
    chk("abort_s_cyc", s_if.cyc, 0);
    tick();
    chk("abort_idle", st(), 32'(ARB_IDLE));
    chk("abort_cnt0", 32'(dut.cnt_q), 0);
    repeat (10) tick();
    chk("late_slave_resp", 32'(s_resp_n - sr), 2);
    chk("late_m0_ack", 32'(m0_ack_n - a0), 0);
    chk("late_m1_ack", 32'(m1_ack_n - a1), 0);

    // m1 reads with an error on the third; m0 waits stalled.
    ack_lat = 1;
    err_at = acc_n + 3;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h0;
    tick();
    chk("m1_grant", st(), 32'(ARB_M1));
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    a0 = m0_ack_n; a1 = m1_ack_n; e0 = m0_err_n; e1 = m1_err_n;
    for (int i = 0; i < 4; i++) begin
      m1_if.addr = 32'(i * 4);
      tick();
      chk($sformatf("m0_wait_stall%0d", i), m0_if.stall, 1);
    end
    m1_if.stb = 1'b0;
    repeat (2) tick();
    chk("m1_err_once", 32'(m1_err_n - e1), 1);
    chk("m1_acks", 32'(m1_ack_n - a1), 3);
    chk("m1_cnt0", 32'(dut.cnt_q), 0);
    chk("m0_no_ack", 32'(m0_ack_n - a0), 0);
    chk("m0_no_err", 32'(m0_err_n - e0), 0);
    m1_if.cyc = 1'b0;
    tick();
    chk("handover_idle_stall", m0_if.stall, 1);
    tick();
    chk("handover_m0", st(), 32'(ARB_M0));
    chk("handover_m0_stall", m0_if.stall, 0);
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
